// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states, decode and merge functions.
// Optional build macro LSU_MISALIGN_TRAP_EN (used by the top) turns misaligned accesses into errors.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_FORMAT,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Stores only have signed encodings; loads additionally accept BU/HU.
    function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: is_illegal = 1'b0;
            F3_BU, F3_HU:     is_illegal = write;
            default:          is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lsb);
        case (funct3)
            F3_H, F3_HU: is_misaligned = lsb[0];
            F3_W:        is_misaligned = |lsb;
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  lsb);
        logic [31:0] merged;
        merged = word;
        case (funct3[1:0])
            2'b00:   merged[{lsb, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   merged[{lsb[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the byte/halfword lane of a memory word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lsb_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[{lsb_i, 3'b000} +: 8];
        half_lane = word_i[{lsb_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
            F3_BU:   data_o = {24'b0, byte_lane};
            F3_HU:   data_o = {16'b0, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only, 1-cycle-latency data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of ignoring the low address bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state_q;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wbuf_q;
    logic              reject_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_error_q;

    logic              reject_d;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        reject_d = is_illegal(req_write, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        reject_d = reject_d | is_misaligned(req_funct3, req_addr[1:0]);
`endif
    end

    lsu_load_align u_align (
        .word_i   (mem_read_data),
        .lsb_i    (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // NOTE: reset is synchronous, so the enables below are also gated with reset to keep a reset cycle access-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wbuf_q       <= '0;
            reject_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        funct3_q     <= req_funct3;
                        addr_q       <= req_addr;
                        wbuf_q       <= req_wdata;
                        reject_q     <= reject_d;
                        resp_rdata_q <= '0;
                        resp_error_q <= 1'b0;
                        // Rejected requests idle one cycle in FORMAT so they answer with a SW's latency.
                        if (reject_d)
                            state_q <= ST_FORMAT;
                        else if (req_write && req_funct3 == F3_W)
                            state_q <= ST_WRITE;
                        else
                            state_q <= ST_READ;
                    end
                end
                ST_READ: state_q <= ST_FORMAT;
                ST_FORMAT: begin
                    if (reject_q) begin
                        resp_error_q <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (!write_q) begin
                        resp_rdata_q <= load_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        wbuf_q  <= store_merge(mem_read_data, wbuf_q, funct3_q, addr_q[1:0]);
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready        = (state_q == ST_IDLE) && !reset;
    assign mem_read_enable  = (state_q == ST_READ) && !reset;
    assign mem_write_enable = (state_q == ST_WRITE) && !reset;
    assign mem_addr         = (state_q == ST_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_write_data   = wbuf_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_error       = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of loads/stores against a 1-cycle-latency word memory model,
// plus hand sequences for reset during a store and back-to-back requests.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    // Word memory model with registered read.
    logic [31:0] mem [64];
    bit          mem_loaded = 1'b0;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]     <= 32'h8899AABB;
            mem_loaded <= 1'b1;
            mem_read_data <= 32'h0;
        end else begin
            if (mem_write_enable) mem[mem_addr[7:2]] <= mem_write_data;
            if (mem_read_enable)  mem_read_data <= mem[mem_addr[7:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request, then watches up to 10 cycles for the response, counting memory enables.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int nr, output int nw, output logic [31:0] waddr);
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0; nr = 0; nw = 0; rd = 32'h0; er = 1'b0; waddr = 32'h0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clock);
            if (mem_read_enable) nr++;
            if (mem_write_enable) begin
                nw++;
                waddr = mem_addr;
            end
            if (resp_valid) begin
                lat = n;
                rd  = resp_rdata;
                er  = resp_error;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nr;
        int          exp_nw;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] rd, waddr;
        logic        er;
        int          lat, nr, nw;
        int          n_ready, n_resp, n_both, n_bad;

        vecs[0]  = '{"lb_13",    1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 3, 1, 0, 32'h8899AABB};
        vecs[1]  = '{"lhu_12",   1'b0, 3'b101, 32'h12, 32'h0,        32'h00008899, 1'b0, 3, 1, 0, 32'h8899AABB};
        vecs[2]  = '{"lh_10",    1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 3, 1, 0, 32'h8899AABB};
        vecs[3]  = '{"lbu_11",   1'b0, 3'b100, 32'h11, 32'h0,        32'h000000AA, 1'b0, 3, 1, 0, 32'h8899AABB};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[4]  = '{"lw_12",    1'b0, 3'b010, 32'h12, 32'h0,        32'h00000000, 1'b1, 2, 0, 0, 32'h8899AABB};
`else
        vecs[4]  = '{"lw_12",    1'b0, 3'b010, 32'h12, 32'h0,        32'h8899AABB, 1'b0, 3, 1, 0, 32'h8899AABB};
`endif
        vecs[5]  = '{"ill_ld",   1'b0, 3'b011, 32'h10, 32'h0,        32'h00000000, 1'b1, 2, 0, 0, 32'h8899AABB};
        vecs[6]  = '{"sb_11",    1'b1, 3'b000, 32'h11, 32'h12345655, 32'h00000000, 1'b0, 4, 1, 1, 32'h889955BB};
        vecs[7]  = '{"sh_12",    1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'h00000000, 1'b0, 4, 1, 1, 32'hCAFE55BB};
        vecs[8]  = '{"lh_12",    1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFCAFE, 1'b0, 3, 1, 0, 32'hCAFE55BB};
        vecs[9]  = '{"sw_20",    1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1, 32'hDEADBEEF};
        vecs[10] = '{"lw_20",    1'b0, 3'b010, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'hDEADBEEF};
        vecs[11] = '{"ill_st",   1'b1, 3'b100, 32'h20, 32'h0,        32'h00000000, 1'b1, 2, 0, 0, 32'hDEADBEEF};
        vecs[12] = '{"sb_23",    1'b1, 3'b000, 32'h23, 32'h00000011, 32'h00000000, 1'b0, 4, 1, 1, 32'h11ADBEEF};
        vecs[13] = '{"lb_23",    1'b0, 3'b000, 32'h23, 32'h0,        32'h00000011, 1'b0, 3, 1, 0, 32'h11ADBEEF};
        vecs[14] = '{"lhu_22",   1'b0, 3'b101, 32'h22, 32'h0,        32'h000011AD, 1'b0, 3, 1, 0, 32'h11ADBEEF};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_ready_low", {31'b0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_mem_en", {30'b0, mem_read_enable, mem_write_enable}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", {31'b0, req_ready}, 32'h1);
        check("idle_rdata", resp_rdata, 32'h0);
        check("idle_error", {31'b0, resp_error}, 32'h0);
        check("idle_mem_addr", mem_addr, 32'h0);

        for (int i = 0; i < 15; i++) begin
            run_req(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, nr, nw, waddr);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_error"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
            check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
            check({vecs[i].name, "_reads"}, nr, vecs[i].exp_nr);
            check({vecs[i].name, "_writes"}, nw, vecs[i].exp_nw);
            check({vecs[i].name, "_word"}, mem[vecs[i].addr[7:2]], vecs[i].exp_word);
            if (vecs[i].exp_nw > 0)
                check({vecs[i].name, "_waddr"}, waddr, {vecs[i].addr[31:2], 2'b00});
        end

        // Reset while an SB sits in WRITE: the write must never reach memory.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h21; req_wdata = 32'h000000FF;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("rmw_read_en", {31'b0, mem_read_enable}, 32'h1);
        check("rmw_mem_addr", mem_addr, 32'h20);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_wr_blocked", {31'b0, mem_write_enable}, 32'h0);
        check("rst_wr_no_resp", {31'b0, resp_valid}, 32'h0);
        @(negedge clock);
        check("rst_hold_ready", {31'b0, req_ready}, 32'h0);
        check("rst_hold_resp", {31'b0, resp_valid}, 32'h0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, req_ready}, 32'h1);
        check("post_rst_addr", mem_addr, 32'h0);
        check("post_rst_word", mem[8], 32'h11ADBEEF);
        @(negedge clock);
        check("post_rst_no_resp", {31'b0, resp_valid}, 32'h0);

        // Back-to-back loads with req_valid held: one accept per 4-cycle load.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        n_ready = 0; n_resp = 0; n_both = 0; n_bad = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (req_ready) n_ready++;
            if (resp_valid) begin
                n_resp++;
                if (resp_rdata !== 32'h11ADBEEF) n_bad++;
            end
            if (req_ready && resp_valid) n_both++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        check("b2b_accepts", n_ready, 4);
        check("b2b_resps", n_resp, 4);
        check("b2b_overlap", n_both, 0);
        check("b2b_data", n_bad, 0);
        @(negedge clock);
        check("b2b_idle", {31'b0, req_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
